// File: rtl/led_display_row_sequencer_pkg.sv
// Shared types for the LED row sequencer: panel geometry, row payload, FSM states.
// SYS_CLK_FREQ is informational only; nothing is timed from it.
package led_display_package;

  localparam int SYS_CLK_FREQ   = 100_000_000;
  localparam int NUM_ROW_PIXELS = 32;
  localparam int NUM_COL_PIXELS = 64;
  localparam int SCAN_ROWS      = NUM_ROW_PIXELS / 2;
  localparam int ADDR_W         = $clog2(SCAN_ROWS);

  // Upper-half (0) and lower-half (1) colour planes for one scan line.
  typedef struct packed {
    logic [NUM_COL_PIXELS-1:0] r0;
    logic [NUM_COL_PIXELS-1:0] g0;
    logic [NUM_COL_PIXELS-1:0] b0;
    logic [NUM_COL_PIXELS-1:0] r1;
    logic [NUM_COL_PIXELS-1:0] g1;
    logic [NUM_COL_PIXELS-1:0] b1;
  } rgb_row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } seq_state_t;

endpackage

// File: rtl/led_display_row_sequencer_fifo.sv
// 2-entry registered FIFO with synchronous clear.
// Latency: push visible at head next cycle. Backpressure: push ignored when full, pop ignored when empty.
module led_display_row_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             n_reset_in,
  input  logic             clr_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_dat_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] pop_dat_out,
  output logic [1:0]       count_out
);

  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_in & (count_q != 2'd2);
    do_pop   = pop_in & (count_q != 2'd0);
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      if (wr_ptr_q) mem1_d = push_dat_in;
      else          mem0_d = push_dat_in;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (clr_in) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_dat_out = rd_ptr_q ? mem1_q : mem0_q;
  assign count_out   = count_q;

endmodule

// File: rtl/led_display_row_sequencer.sv
// Tags buffered rows with scan address/frame start and streams them to the PHY; repeats last row on underflow.
// Latency: 2 clk push-to-valid from S_FILL, 1 clk pop-to-output in S_RUN. Backpressure: output held until accepted, FIFO ready drops at 2 entries.
// Optional LED_DISPLAY_SEQ_STATS_EN adds a saturating underflow_count_out.
module led_display_row_sequencer
  import led_display_package::*;
(
  input  logic              clk_in,
  input  logic              n_reset_in,
  input  logic              enable_in,
  input  rgb_row_t          row_in,
  input  logic              row_valid_in,
  output logic              row_ready_out,
  output rgb_row_t          row_out,
  output logic [ADDR_W-1:0] row_addr_out,
  output logic              frame_start_out,
  output logic              row_valid_out,
  input  logic              row_ready_in
`ifdef LED_DISPLAY_SEQ_STATS_EN
  ,
  output logic [15:0]       underflow_count_out
`endif
);

  seq_state_t        state_q, state_d;
  rgb_row_t          row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic              valid_q, valid_d;
  logic              fs_q, fs_d;

  rgb_row_t          fifo_dat;
  logic [1:0]        fifo_count;
  logic              fifo_push, fifo_pop, fifo_clr, fifo_nonempty;
  logic              accept;

  led_display_row_fifo #(
    .WIDTH($bits(rgb_row_t))
  ) u_fifo (
    .clk_in      (clk_in),
    .n_reset_in  (n_reset_in),
    .clr_in      (fifo_clr),
    .push_in     (fifo_push),
    .push_dat_in (row_in),
    .pop_in      (fifo_pop),
    .pop_dat_out (fifo_dat),
    .count_out   (fifo_count)
  );

  // Ready depends only on registered state and enable, never on row_ready_in.
  assign row_ready_out = enable_in & ((state_q == S_FILL) | (state_q == S_RUN)) &
                         (fifo_count != 2'd2);
  assign fifo_push     = row_valid_in & row_ready_out;
  assign fifo_nonempty = (fifo_count != 2'd0);
  assign accept        = valid_q & row_ready_in;
  assign addr_nxt      = (addr_q == ADDR_W'(SCAN_ROWS - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    fifo_pop = 1'b0;
    fifo_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_in) state_d = S_FILL;
      end
      S_FILL: begin
        if (!enable_in) begin
          state_d = S_FLUSH;
        end else if (fifo_nonempty) begin
          row_d    = fifo_dat;
          fifo_pop = 1'b1;
          valid_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (!enable_in) begin
          state_d = S_FLUSH;
          if (accept) valid_d = 1'b0;
        end else if (accept) begin
          addr_d = addr_nxt;
          // Empty FIFO leaves row_d untouched: the last row repeats at the next address.
          if (fifo_nonempty) begin
            row_d    = fifo_dat;
            fifo_pop = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (!(valid_q && !row_ready_in)) begin
          fifo_clr = 1'b1;
          valid_d  = 1'b0;
          addr_d   = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fs_d = valid_d & (addr_d == '0);
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
    end
  end

  assign row_out         = row_q;
  assign row_addr_out    = addr_q;
  assign row_valid_out   = valid_q;
  assign frame_start_out = fs_q;

`ifdef LED_DISPLAY_SEQ_STATS_EN
  logic        repeat_evt;
  logic [15:0] ufl_cnt_q, ufl_cnt_d;

  assign repeat_evt = (state_q == S_RUN) & enable_in & accept & ~fifo_nonempty;

  always_comb begin
    ufl_cnt_d = ufl_cnt_q;
    if (fifo_clr)                                 ufl_cnt_d = 16'd0;
    else if (repeat_evt && ufl_cnt_q != 16'hFFFF) ufl_cnt_d = ufl_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) ufl_cnt_q <= 16'd0;
    else             ufl_cnt_q <= ufl_cnt_d;
  end

  assign underflow_count_out = ufl_cnt_q;
`endif

endmodule

// File: tb/tb_led_display_row_sequencer.sv
// Scoreboard bench for led_display_row_sequencer: stimulus queues expected beats, PHY-side monitor pops and compares.
// Builds with or without LED_DISPLAY_SEQ_STATS_EN.
module tb_led_display_row_sequencer;
  import led_display_package::*;

  typedef struct {
    rgb_row_t          row;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clk_in = 1'b0;
  logic              n_reset_in;
  logic              enable_in;
  rgb_row_t          row_in;
  logic              row_valid_in;
  logic              row_ready_out;
  rgb_row_t          row_out;
  logic [ADDR_W-1:0] row_addr_out;
  logic              frame_start_out;
  logic              row_valid_out;
  logic              row_ready_in;
`ifdef LED_DISPLAY_SEQ_STATS_EN
  logic [15:0]       underflow_count_out;
`endif

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr;
  int                total = 0;
  int                bad = 0;
  int                phy_budget = 0;
  int                acc_cnt = 0;
  int                fs_cnt = 0;
  int                first_cyc = 0;
  int                last_cyc = 0;
  int                cyc = 0;

  led_display_row_sequencer dut (
    .clk_in          (clk_in),
    .n_reset_in      (n_reset_in),
    .enable_in       (enable_in),
    .row_in          (row_in),
    .row_valid_in    (row_valid_in),
    .row_ready_out   (row_ready_out),
    .row_out         (row_out),
    .row_addr_out    (row_addr_out),
    .frame_start_out (frame_start_out),
    .row_valid_out   (row_valid_out),
    .row_ready_in    (row_ready_in)
`ifdef LED_DISPLAY_SEQ_STATS_EN
    ,
    .underflow_count_out (underflow_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rgb_row_t mk_row(input int k);
    rgb_row_t r;
    r.r0 = {8'h10, 48'h0, 8'(k)};
    r.g0 = {8'h20, 48'h0, 8'(k)};
    r.b0 = {8'h30, 48'h0, 8'(k)};
    r.r1 = {8'h40, 48'h0, 8'(k)};
    r.g1 = {8'h50, 48'h0, 8'(k)};
    r.b1 = {8'h60, 48'hABCD, 8'(k)};
    return r;
  endfunction

  task automatic push_exp(input rgb_row_t d);
    exp_t e;
    e.row = d;
    e.addr = exp_addr;
    exp_q.push_back(e);
    exp_addr = exp_addr + 1'b1;
  endtask

  // Present one row upstream and hold it until the FIFO takes it.
  task automatic push_row(input rgb_row_t d);
    int n = 0;
    row_in = d;
    row_valid_in = 1'b1;
    @(negedge clk_in);
    while (!row_ready_out && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (!row_ready_out) begin
      total++;
      bad++;
      $display("FAIL push_timeout: ready got 0 expected 1");
    end
    @(posedge clk_in);
    #1;
    row_valid_in = 1'b0;
  endtask

  task automatic send(input rgb_row_t d);
    push_exp(d);
    push_row(d);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || phy_budget != 0) && n < 500) begin
      @(posedge clk_in);
      n++;
    end
    #1;
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_row"},   row_out, '0);
    check({tag, "_addr"},  row_addr_out, '0);
    check({tag, "_valid"}, row_valid_out, 1'b0);
    check({tag, "_fs"},    frame_start_out, 1'b0);
    check({tag, "_rdy"},   row_ready_out, 1'b0);
`ifdef LED_DISPLAY_SEQ_STATS_EN
    check({tag, "_ufl"},   underflow_count_out, 16'd0);
`endif
  endtask

  // Async reset: outputs must clear 1 time unit after assertion, without a clock edge.
  task automatic do_reset();
    enable_in = 1'b0;
    row_valid_in = 1'b0;
    row_in = '0;
    phy_budget = 0;
    n_reset_in = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset_exp_left", exp_q.size(), 0);
    repeat (2) @(posedge clk_in);
    #1;
    n_reset_in = 1'b1;
    exp_addr = '0;
    acc_cnt = 0;
    fs_cnt = 0;
    @(posedge clk_in);
    #1;
    enable_in = 1'b1;
  endtask

  // PHY side: drive ready from the accept budget, then score every accepted beat.
  initial begin
    exp_t e;
    row_ready_in = 1'b0;
    forever begin
      @(negedge clk_in);
      row_ready_in = (phy_budget > 0);
      if (n_reset_in && row_valid_out && row_ready_in) begin
        phy_budget--;
        acc_cnt++;
        if (acc_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (frame_start_out) fs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got addr %0d expected no beat", row_addr_out);
        end else begin
          e = exp_q.pop_front();
          check("beat_row", row_out, e.row);
          check("beat_addr", row_addr_out, e.addr);
          check("beat_fs", frame_start_out, (e.addr == '0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset_in = 1'b1;
    enable_in = 1'b0;
    row_valid_in = 1'b0;
    row_in = '0;
    exp_addr = '0;
    #2;
    do_reset();

    // Stream of 32 rows with PHY always ready: two full frames, no bubbles.
    phy_budget = 32;
    for (int k = 0; k < 32; k++) send(mk_row(k));
    wait_drain();
    check("stream_acc", acc_cnt, 32);
    check("stream_fs", fs_cnt, 2);
    check("stream_gap", last_cyc - first_cyc, 31);
    // Underflow after the wrap: last row repeats at address 0 with frame start.
    check("wrap_row", row_out, mk_row(31));
    check("wrap_addr", row_addr_out, 4'd0);
    check("wrap_fs", frame_start_out, 1'b1);
    check("wrap_valid", row_valid_out, 1'b1);

    // Reset while a row is pending on the output.
    do_reset();

    // Backpressure: output holds, FIFO absorbs two more rows then deasserts ready.
    send(mk_row(200));
    send(mk_row(201));
    send(mk_row(202));
    check("bp_rdy_full", row_ready_out, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_in);
      #1;
      check("bp_row_stable", row_out, mk_row(200));
      check("bp_addr_stable", row_addr_out, 4'd0);
      check("bp_rdy_low", row_ready_out, 1'b0);
    end
    phy_budget = 4;
    send(mk_row(203));
    wait_drain();
    check("bp_repeat_row", row_out, mk_row(203));
    check("bp_repeat_addr", row_addr_out, 4'd4);
    do_reset();

    // Underflow: upstream stops after row 5; addresses 6 and 7 carry row 5 data.
    phy_budget = 7;
    for (int k = 0; k < 6; k++) send(mk_row(100 + k));
    push_exp(mk_row(105));
    wait_drain();
    check("ufl_row", row_out, mk_row(105));
    check("ufl_addr", row_addr_out, 4'd7);
    check("ufl_valid", row_valid_out, 1'b1);
`ifdef LED_DISPLAY_SEQ_STATS_EN
    check("ufl_count", underflow_count_out, 16'd2);
`endif
    // Flush from underflow: pending addr 7 beat goes out, then everything clears.
    enable_in = 1'b0;
    push_exp(mk_row(105));
    phy_budget = 1;
    wait_drain();
    @(posedge clk_in);
    #1;
    check("ufl_flush_valid", row_valid_out, 1'b0);
    check("ufl_flush_addr", row_addr_out, 4'd0);
`ifdef LED_DISPLAY_SEQ_STATS_EN
    check("ufl_flush_count", underflow_count_out, 16'd0);
`endif
    do_reset();

    // Disable with a pending output and one row buffered.
    send(mk_row(50));
    push_row(mk_row(51));
    enable_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      check("dis_valid_held", row_valid_out, 1'b1);
      check("dis_row_held", row_out, mk_row(50));
      check("dis_rdy", row_ready_out, 1'b0);
    end
    phy_budget = 1;
    wait_drain();
    check("dis_valid_clr", row_valid_out, 1'b0);
    check("dis_addr_clr", row_addr_out, 4'd0);
    check("dis_fs_clr", frame_start_out, 1'b0);
    check("dis_rdy_clr", row_ready_out, 1'b0);
    repeat (2) @(posedge clk_in);
    #1;
    check("dis_idle_valid", row_valid_out, 1'b0);
    // Re-enable: the discarded buffered row never appears; restart at address 0.
    enable_in = 1'b1;
    exp_addr = '0;
    phy_budget = 1;
    send(mk_row(60));
    wait_drain();
    check("reen_repeat_row", row_out, mk_row(60));
    check("reen_repeat_addr", row_addr_out, 4'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
